// File: rtl/pipeline_controller_pkg.sv
// rtl/pipeline_controller_pkg.sv - shared constants, types and helpers for the pipeline sequencer
package pipeline_ctrl_pkg;

  localparam int DEFAULT_STAGES = 6;
  localparam int MAX_STAGES     = 16;

  typedef logic [MAX_STAGES-1:0] stage_vec_t;

  // Width of a stage index; a single-bit floor keeps degenerate depths legal.
  function automatic int stage_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pipe_stage_slot.sv
// rtl/pipe_stage_slot.sv - one pipeline stage occupancy bit with advance/stall decode
module pipe_stage_slot (
  input  logic clk,
  input  logic reset,
  input  logic done,
  input  logic downstream_free,
  input  logic killed,
  input  logic fill,
  output logic advance,
  output logic stall,
  output logic occ
);

  assign advance = occ & done & downstream_free & ~killed;
  assign stall   = occ & ~advance & ~killed;

  always_ff @(posedge clk) begin
    if (reset) begin
      occ <= 1'b0;
    end else if (killed) begin
      occ <= 1'b0;
    end else begin
      occ <= (occ & ~advance) | fill;
    end
  end

endmodule

// File: rtl/pipeline_controller.sv
// rtl/pipeline_controller.sv - N-stage in-order sequencer: issue, advance/stall chain, flush, retire counter
module pipeline_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int NUM_STAGES = DEFAULT_STAGES,
  parameter bit PIPELINED  = 1'b1,
  parameter int CNT_W      = 32
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  fetch_ready,
  input  logic [NUM_STAGES-1:0]                 stage_done,
  input  logic                                  flush,
  input  logic [stage_idx_w(NUM_STAGES)-1:0]    flush_stage,
  output logic                                  issue,
  output logic [NUM_STAGES-1:0]                 valid,
  output logic [NUM_STAGES-1:0]                 advance,
  output logic [NUM_STAGES-1:0]                 stalls,
  output logic                                  busy,
  output logic [CNT_W-1:0]                      retire_count
);

  logic [NUM_STAGES-1:0] occ;
  logic [NUM_STAGES-1:0] killed;
  logic [NUM_STAGES-1:0] ds_free;
  logic [NUM_STAGES-1:0] fill;
  logic                  free;

  // Free-slot chain ripples tail to head; reset is folded into killed so every
  // combinational output reads zero while reset is held.
  always_comb begin
    free    = 1'b1;
    killed  = '0;
    ds_free = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      killed[i]  = reset | (flush & (int'(flush_stage) >= i));
      ds_free[i] = free;
      free       = ~occ[i] | (stage_done[i] & free & ~killed[i]);
    end
  end

  assign issue = fetch_ready & ~flush & ~reset & (~occ[0] | advance[0])
               & (PIPELINED || (occ == '0));

  assign fill = {advance[NUM_STAGES-2:0], issue};

  for (genvar i = 0; i < NUM_STAGES; i++) begin : g_slot
    pipe_stage_slot u_slot (
      .clk             (clk),
      .reset           (reset),
      .done            (stage_done[i]),
      .downstream_free (ds_free[i]),
      .killed          (killed[i]),
      .fill            (fill[i]),
      .advance         (advance[i]),
      .stall           (stalls[i]),
      .occ             (occ[i])
    );
  end

  assign valid = occ;
  assign busy  = |occ;

  always_ff @(posedge clk) begin
    if (reset) begin
      retire_count <= '0;
    end else if (advance[NUM_STAGES-1]) begin
      retire_count <= retire_count + CNT_W'(1);
    end
  end

endmodule
